uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that shares the single UART transmit path among up to four byte requesters. Arbitrates pending requests, issues one byte per frame slot to the transmitter as a one-cycle `tx_data_valid` pulse with `tx_data_in`, and then holds off further issues for a full frame time counted from `BPS_PARA`. The transmitter has no busy output, so this block alone guarantees bytes are never overlapped. It sits between client logic and the `Baud`/`Uart_Tx` pair inside the UART bus top.

## Interface
- `NUM_REQ`, 4, number of requesters (legal 2..4).
- `BPS_PARA`, 1250, system clocks per bit; must equal the value given to the transmitter's `Baud`.
- `FRAME_BITS`, 10, bits per frame (start + 8 data + stop).
- `GAP_CYCLES`, 2, extra idle clocks appended after each frame.
- `clk_in`  in  1  system clock (12 MHz).
- `rst_in`  in  1  reset, synchronous, active-high.
- `sched_en`  in  1  when low, no new grants; a frame already in progress completes normally.
- `req_valid`  in  NUM_REQ  per-requester byte pending.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept pulse; the byte transfers when valid&ready.
- `tx_data_valid`  out  1  one-cycle strobe to the transmitter.
- `tx_data_in`  out  8  byte to the transmitter; valid while `tx_data_valid` is high and held afterwards.
- `grant_id`  out  2  index of the last granted requester.
- `busy`  out  1  high from the issue cycle through the end of the frame slot.

## Operation
- Derived constant: FRAME_CYCLES = FRAME_BITS*BPS_PARA + GAP_CYCLES. The down-counter is 24 bits wide. Elaboration fails if FRAME_CYCLES ≥ 2^24 or FRAME_CYCLES < 2.
- States:
  - IDLE: if `sched_en` and any `req_valid` bit is set, select winner g, go to ISSUE.
  - ISSUE (exactly 1 cycle): `req_ready[g]`=1, `tx_data_valid`=1, `tx_data_in`=req_data[g], `grant_id`=g. Load the counter with FRAME_CYCLES-2 and go to WAIT.
  - WAIT: decrement the counter; at 0, return to IDLE.
- All outputs are registered. `req_ready` and `tx_data_valid` are never high outside ISSUE.
- Requester rule: `req_valid` must stay high with stable data until `req_ready`. Behaviour is undefined if it is withdrawn early; the scheduler still issues whatever data is present in ISSUE.
- Arbitration is round-robin. A pointer holds the last grant (reset to NUM_REQ-1, so requester 0 wins first). Search order is pointer+1, pointer+2, … modulo NUM_REQ. The pointer updates only on a grant.
- `sched_en` is sampled only in IDLE. Deasserting it during WAIT does not shorten or extend the slot.
- `req_valid` bits at index ≥ NUM_REQ are ignored; the corresponding `req_ready` bits are tied to 0.
- Reset, including mid-frame: state IDLE, counter 0, pointer NUM_REQ-1, all outputs 0 (`tx_data_in`=8'h00, `grant_id`=0, `busy`=0). The transmitter is reset by the same event, so the abandoned frame is not timed out.

## Timing
- A request visible in IDLE cycle t produces `req_ready`/`tx_data_valid` high during cycle t+1.
- Issue-to-issue spacing is exactly FRAME_CYCLES clocks under continuous requests: cycles t+1, t+1+FRAME_CYCLES, and so on.
- `busy` is high for exactly FRAME_CYCLES consecutive cycles starting at the ISSUE cycle.
- A request arriving during ISSUE or WAIT is first considered in the IDLE cycle following WAIT. Zero-wait back-to-back issue is achieved by IDLE→ISSUE in that cycle.
- A request and `sched_en` rising in the same cycle: the request is granted.

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest-index valid requester always wins, and the pointer logic is removed (`grant_id` still reports the winner).
  - Undefined: round-robin as specified above.

## Test plan
Bench uses BPS_PARA=4, FRAME_BITS=10, GAP_CYCLES=2, so FRAME_CYCLES=42.
- Single byte: req_valid=4'b0010, data1=8'hA5 in cycle 10. Required: `req_ready`=4'b0010 and `tx_data_valid` with `tx_data_in`=8'hA5 in cycle 11; `busy` high for cycles 11–52; next issue possible no earlier than cycle 53.
- All four requesters held valid with data 8'h10..8'h13. Required: issues at cycles 1, 43, 85, 127 carrying 8'h10, 8'h11, 8'h12, 8'h13; the fifth issue returns to requester 0. With `UART_TX_SCHED_FIXED_PRIO_EN` defined, all issues go to requester 0.
- `sched_en`=0 with req0 valid. Required: no `tx_data_valid` for 100 cycles. Raise `sched_en`: issue occurs on the next cycle.
- Drop `sched_en` 5 cycles after an issue. Required: `busy` still lasts 42 cycles and no further issue follows.
- Assert `rst_in` 20 cycles into WAIT with req2 valid. Required: all outputs 0 in the next cycle; after release, req2 is issued one cycle after IDLE is re-entered.
- Requester 3 becomes valid mid-WAIT while requester 0 is continuously valid, last grant=0. Required: the next issue goes to requester 3.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among up to four byte requesters.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
//
// state   | meaning
// S_IDLE  | no frame in flight; grant on sched_en and any pending request
// S_ISSUE | one-cycle strobe of the granted byte to the transmitter
// S_WAIT  | frame slot counting down; count 0 is also the next grant point
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int BPS_PARA   = 1250,
    parameter int FRAME_BITS = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   sched_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_data_valid,
    output logic [7:0]             tx_data_in,
    output logic [1:0]             grant_id,
    output logic                   busy
);
    localparam int          FRAME_CYCLES = FRAME_BITS * BPS_PARA + GAP_CYCLES;
    localparam logic [23:0] CNT_LOAD     = 24'(FRAME_CYCLES - 2);

    generate
        if (FRAME_CYCLES >= (1 << 24) || FRAME_CYCLES < 2) begin : g_bad_frame
            $error("uart_tx_sched: FRAME_CYCLES out of range for 24-bit counter");
        end
        if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
            $error("uart_tx_sched: NUM_REQ must be 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [23:0]         r_cnt;
    logic [23:0]         w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_ready;
    logic                r_valid;
    logic [7:0]          r_data;
    logic [1:0]          r_grant;
    logic                r_busy;

    logic [3:0]          w_valid_pad;
    logic [3:0][7:0]     w_bytes;
    logic                w_any;
    logic [1:0]          w_pick;
    logic                w_issue;
    logic [3:0]          w_onehot;

    always_comb begin
        w_valid_pad                = '0;
        w_valid_pad[NUM_REQ-1:0]   = req_valid;
        w_bytes                    = '0;
        w_bytes[NUM_REQ-1:0]       = req_data;
    end

    assign w_any    = |w_valid_pad;
    assign w_onehot = 4'b0001 << w_pick;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_valid_pad[i]) begin
                w_pick = i[1:0];
            end
        end
    end
`else
    logic [1:0] r_ptr;

    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_pick = rr_pick(w_valid_pad, r_ptr);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr <= 2'(NUM_REQ - 1);
        end else if (w_issue) begin
            r_ptr <= w_pick;
        end
    end
`endif

    // Count 0 is the slot boundary: granting here keeps back-to-back issues exactly FRAME_CYCLES apart.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue = sched_en && w_any;
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_LOAD;
            end
            S_WAIT: begin
                if (r_cnt == 24'd0) begin
                    w_issue     = sched_en && w_any;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_issue) begin
            w_state_nxt = S_ISSUE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_grant <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_issue ? w_onehot[NUM_REQ-1:0] : '0;
            r_valid <= w_issue;
            if (w_issue) begin
                r_data  <= w_bytes[w_pick];
                r_grant <= w_pick;
            end
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ready     = r_ready;
    assign tx_data_valid = r_valid;
    assign tx_data_in    = r_data;
    assign grant_id      = r_grant;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized traffic
// compared against a slot-timing reference model (frame = 42 clocks).
module tb_uart_tx_sched;
    localparam int NREQ  = 4;
    localparam int BPS   = 4;
    localparam int FBITS = 10;
    localparam int GAP   = 2;
    localparam int F     = FBITS * BPS + GAP;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        sched_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_data_valid;
    logic [7:0]  tx_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    always #5 clk_in = ~clk_in;

    uart_tx_sched #(
        .NUM_REQ(NREQ), .BPS_PARA(BPS), .FRAME_BITS(FBITS), .GAP_CYCLES(GAP)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sched_en(sched_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_data_valid(tx_data_valid), .tx_data_in(tx_data_in),
        .grant_id(grant_id), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: time of last issue and last winner; a new issue is allowed
    // once a full frame has elapsed since the previous one.
    int          m_last       = NREQ - 1;
    int          m_last_issue = -1000;
    logic        exp_valid;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_data;
    logic [1:0]  exp_grant;
    logic        exp_busy;

    function automatic int model_pick(input logic [3:0] v, input int last);
        int base;
        int idx;
        base = last;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        base = NREQ - 1;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = (base + k) % NREQ;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {req_ready, tx_data_valid, tx_data_in, grant_id, busy};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_ready, exp_valid, exp_data, exp_grant, exp_busy};
    endfunction

    task automatic tick();
        int w;
        if (rst_in) begin
            m_last       = NREQ - 1;
            m_last_issue = -1000;
            exp_valid = 1'b0; exp_ready = 4'b0; exp_data = 8'h00; exp_grant = 2'd0; exp_busy = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_ready = 4'b0;
            if (sched_en && req_valid != 4'b0 && (cyc + 1 - m_last_issue) >= F) begin
                w            = model_pick(req_valid, m_last);
                exp_valid    = 1'b1;
                exp_ready    = 4'b0001 << w;
                exp_data     = req_data[8*w +: 8];
                exp_grant    = 2'(w);
                m_last       = w;
                m_last_issue = cyc + 1;
            end
            exp_busy = (cyc + 1 - m_last_issue) < F;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; sched_en = 1'b1; req_valid = 4'hF; req_data = 32'h13121110;
        repeat (3) begin
            tick();
            n_tests++;
            if (dut_vec() !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want 0000", dut_vec());
            end
        end
        rst_in = 1'b0; req_valid = 4'h0; sched_en = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        int issue_at;
        int busy_cnt;
        do_reset();
        sched_en = 1'b1;
        repeat (5) tick();
        req_valid = 4'b0010; req_data = 32'h0000A500;
        tick();
        issue_at = cyc;
        n_tests++;
        if ({req_ready, tx_data_valid, tx_data_in, grant_id, busy} !== {4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got rdy=%b v=%b d=%h g=%0d b=%b want rdy=0010 v=1 d=a5 g=1 b=1",
                     req_ready, tx_data_valid, tx_data_in, grant_id, busy);
        end
        req_data = 32'h00005A00;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_data_valid) break;
            if (busy) busy_cnt++;
        end
        n_tests++;
        if (busy_cnt !== F) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, F);
        end
        n_tests++;
        if (!tx_data_valid || cyc - issue_at !== F || tx_data_in !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_next_issue: got spacing=%0d v=%b d=%h want spacing=%0d v=1 d=5a",
                     cyc - issue_at, tx_data_valid, tx_data_in, F);
        end
        req_valid = 4'b0;
        repeat (F + 2) tick();
        n_tests++;
        if (busy !== 1'b0 || tx_data_in !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_idle_hold: got busy=%b d=%h want busy=0 d=5a", busy, tx_data_in);
        end
    endtask

    task automatic test_round_robin();
        int start;
        int got_n;
        int e;
        do_reset();
        req_data = 32'h13121110; req_valid = 4'hF; sched_en = 1'b1;
        start = cyc;
        got_n = 0;
        for (int i = 0; i < 4 * F + 2; i++) begin
            tick();
            if (tx_data_valid) begin
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
                e = 0;
`else
                e = got_n % NREQ;
`endif
                n_tests++;
                if (cyc - start !== 1 + got_n * F || grant_id !== 2'(e) ||
                    tx_data_in !== 8'(8'h10 + e) || req_ready !== 4'(4'b0001 << e)) begin
                    n_fail++;
                    $display("FAIL rr_issue%0d: got t=%0d g=%0d d=%h rdy=%b want t=%0d g=%0d d=%h",
                             got_n, cyc - start, grant_id, tx_data_in, req_ready,
                             1 + got_n * F, e, 8'(8'h10 + e));
                end
                got_n++;
            end
        end
        n_tests++;
        if (got_n !== 5) begin
            n_fail++;
            $display("FAIL rr_issue_count: got %0d want 5", got_n);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_sched_en();
        int seen;
        int busy_cnt;
        do_reset();
        sched_en = 1'b0; req_valid = 4'b0001; req_data = 32'h000000C3;
        seen = 0;
        repeat (100) begin
            tick();
            if (tx_data_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL en_low_blocks: got %0d issues want 0", seen);
        end
        sched_en = 1'b1;
        tick();
        n_tests++;
        if ({tx_data_valid, req_ready, grant_id, tx_data_in} !== {1'b1, 4'b0001, 2'd0, 8'hC3}) begin
            n_fail++;
            $display("FAIL en_rise_issue: got v=%b rdy=%b g=%0d d=%h want v=1 rdy=0001 g=0 d=c3",
                     tx_data_valid, req_ready, grant_id, tx_data_in);
        end
        busy_cnt = busy ? 1 : 0;
        seen = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 5) sched_en = 1'b0;
            tick();
            if (busy) busy_cnt++;
            if (tx_data_valid) seen++;
        end
        n_tests++;
        if (busy_cnt !== F || seen !== 0) begin
            n_fail++;
            $display("FAIL en_drop_slot: got busy=%0d issues=%0d want busy=%0d issues=0", busy_cnt, seen, F);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        sched_en = 1'b1; req_valid = 4'b0100; req_data = 32'h00770000;
        tick();
        repeat (21) tick();
        n_tests++;
        if (busy !== 1'b1 || tx_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_busy: got busy=%b v=%b want busy=1 v=0", busy, tx_data_valid);
        end
        rst_in = 1'b1;
        tick();
        n_tests++;
        if (dut_vec() !== 16'h0000) begin
            n_fail++;
            $display("FAIL midframe_reset_zero: got %h want 0000", dut_vec());
        end
        rst_in = 1'b0;
        tick();
        n_tests++;
        if ({tx_data_valid, req_ready, grant_id, tx_data_in, busy} !== {1'b1, 4'b0100, 2'd2, 8'h77, 1'b1}) begin
            n_fail++;
            $display("FAIL midframe_reissue: got v=%b rdy=%b g=%0d d=%h b=%b want v=1 rdy=0100 g=2 d=77 b=1",
                     tx_data_valid, req_ready, grant_id, tx_data_in, busy);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_late_requester();
        int issue_at;
        int e;
        do_reset();
        sched_en = 1'b1; req_valid = 4'b0001; req_data = 32'hD3000001;
        tick();
        issue_at = cyc;
        n_tests++;
        if (tx_data_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL late_first: got v=%b g=%0d want v=1 g=0", tx_data_valid, grant_id);
        end
        repeat (10) tick();
        req_valid = 4'b1001;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            if (tx_data_valid) break;
        end
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        e = 0;
`else
        e = 3;
`endif
        n_tests++;
        if (!tx_data_valid || cyc - issue_at !== F || grant_id !== 2'(e) || tx_data_in !== req_data[8*e +: 8]) begin
            n_fail++;
            $display("FAIL late_winner: got v=%b t=%0d g=%0d d=%h want v=1 t=%0d g=%0d d=%h",
                     tx_data_valid, cyc - issue_at, grant_id, tx_data_in, F, e, req_data[8*e +: 8]);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_random();
        logic [3:0] prev_ready;
        int         errs;
        do_reset();
        req_valid  = 4'b0;
        sched_en   = 1'b1;
        prev_ready = 4'b0;
        errs       = 0;
        for (int i = 0; i < 1500; i++) begin
            req_valid = req_valid & ~prev_ready;
            prev_ready = req_ready;
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 15) == 0) begin
                    req_valid[r]        = 1'b1;
                    req_data[8*r +: 8]  = 8'($urandom);
                end
            end
            if ($urandom_range(0, 39) == 0) sched_en = ~sched_en;
            rst_in = ($urandom_range(0, 299) == 0);
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        rst_in = 1'b0;
        req_valid = 4'b0;
    endtask

    initial begin
        rst_in = 1'b1; sched_en = 1'b0; req_valid = 4'b0; req_data = 32'h0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_sched_en();
        test_reset_midframe();
        test_late_requester();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
